// File: rtl/vx_ipdom_stack_mw_pkg.sv
// vx_ipdom_stack_mw_pkg: shared op encoding and sizing helper for the IPDOM stack
package vx_ipdom_stack_mw_pkg;

    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } ipdom_op_e;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_ipdom_stack_mw_store.sv
// vx_ipdom_stack_mw_store: entry RAM, one write port (full entry or set bit only), registered read
module vx_ipdom_stack_mw_store #(
    parameter int DATAW = 65,
    parameter int SIZE  = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_full,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DATAW-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [DATAW-1:0] rd_data
);

    logic [DATAW-1:0] mem [SIZE];

    // write full entry on push or only the set bit on first pop; read returns pre-write contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_full)
                mem[wr_addr] <= wr_data;
            else
                mem[wr_addr][DATAW-1] <= 1'b1;
        end
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vx_ipdom_stack_mw.sv
// vx_ipdom_stack_mw: per-warp IPDOM reconvergence stacks; IPDOM_STACK_ERR_EN enables sticky error tracking
module vx_ipdom_stack_mw
    import vx_ipdom_stack_mw_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int NUM_WARPS = 4,
    localparam int ADDRW    = log2up(DEPTH),
    localparam int WIDW     = log2up(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDW-1:0]      req_wid,
    input  logic                 req_push,
    input  logic [WIDTH-1:0]     req_q0,
    input  logic [WIDTH-1:0]     req_q1,
    input  logic                 flush_valid,
    input  logic [WIDW-1:0]      flush_wid,
    output logic                 rsp_valid,
    output logic [WIDW-1:0]      rsp_wid,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_set,
    output logic [NUM_WARPS-1:0] empty,
    output logic [NUM_WARPS-1:0] full,
    output logic [NUM_WARPS-1:0] err
);

    typedef struct packed {
        logic             set;
        logic [WIDTH-1:0] q1;
        logic [WIDTH-1:0] q0;
    } entry_t;

    logic [ADDRW:0]     cnt [NUM_WARPS];
    logic [NUM_WARPS-1:0] top_set;
    logic [DEPTH-1:0]   set_q [NUM_WARPS];
    logic [ADDRW:0]     cur_cnt;
    logic [ADDRW-1:0]   top_ptr, nxt_ptr;
    logic               cur_top, next_top, fire, is_push, bad, do_push, do_pop;
    entry_t             wr_data, rd_data;

    assign req_ready = !(flush_valid && flush_wid == req_wid);
    assign fire      = req_valid && req_ready;
    assign is_push   = req_push == OP_PUSH;
    assign do_push   = fire && is_push && !bad;
    assign do_pop    = fire && !is_push && !bad;
    assign wr_data   = '{set: 1'b0, q1: req_q1, q0: req_q0};
    assign rsp_data  = rd_data.set ? rd_data.q0 : rd_data.q1;
    assign rsp_set   = !rd_data.set;

    // selected warp's pointer view; the post-pop top_set comes from the register mirror, not RAM
    always_comb begin
        cur_cnt  = cnt[req_wid];
        cur_top  = top_set[req_wid];
        top_ptr  = cur_cnt[ADDRW-1:0] - ADDRW'(1);
        nxt_ptr  = cur_cnt[ADDRW-1:0] - ADDRW'(2);
        next_top = (cur_cnt > (ADDRW+1)'(1)) && set_q[req_wid][nxt_ptr];
    end

    // per-warp status flags
    always_comb begin
        empty = '0;
        full  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            empty[w] = cnt[w] == '0;
            full[w]  = cnt[w] == (ADDRW+1)'(DEPTH);
        end
    end

    // entry counts and top_set per warp; flush overrides the same-cycle update of its warp
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++)
                cnt[w] <= '0;
            top_set <= '0;
        end else begin
            if (do_push) begin
                cnt[req_wid]     <= cur_cnt + (ADDRW+1)'(1);
                top_set[req_wid] <= 1'b0;
            end
            if (do_pop) begin
                if (!cur_top)
                    top_set[req_wid] <= 1'b1;
                else begin
                    cnt[req_wid]     <= cur_cnt - (ADDRW+1)'(1);
                    top_set[req_wid] <= next_top;
                end
            end
            if (flush_valid) begin
                cnt[flush_wid]     <= '0;
                top_set[flush_wid] <= 1'b0;
            end
        end
    end

    // register copy of each entry's set bit so pointer logic never waits on RAM reads
    always_ff @(posedge clk) begin
        if (do_push)
            set_q[req_wid][cur_cnt[ADDRW-1:0]] <= 1'b0;
        if (do_pop && !cur_top)
            set_q[req_wid][top_ptr] <= 1'b1;
    end

    // response tag aligned with the registered RAM read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_wid   <= '0;
        end else begin
            rsp_valid <= do_pop;
            if (do_pop)
                rsp_wid <= req_wid;
        end
    end

`ifdef IPDOM_STACK_ERR_EN
    assign bad = fire && (is_push ? cur_cnt == (ADDRW+1)'(DEPTH) : cur_cnt == '0);

    // sticky error per warp, cleared by flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err <= '0;
        else begin
            if (bad)
                err[req_wid] <= 1'b1;
            if (flush_valid)
                err[flush_wid] <= 1'b0;
        end
    end
`else
    assign bad = 1'b0;
    assign err = '0;

    // illegal operations are undefined here; catch them in simulation
    always_ff @(posedge clk) begin
        if (reset_n && fire)
            assert (is_push ? cur_cnt != (ADDRW+1)'(DEPTH) : cur_cnt != '0);
    end
`endif

    vx_ipdom_stack_mw_store #(
        .DATAW ($bits(entry_t)),
        .SIZE  (NUM_WARPS * DEPTH),
        .AW    (WIDW + ADDRW)
    ) store (
        .clk     (clk),
        .wr_en   (do_push || (do_pop && !cur_top)),
        .wr_full (do_push),
        .wr_addr ({req_wid, do_push ? cur_cnt[ADDRW-1:0] : top_ptr}),
        .wr_data (wr_data),
        .rd_en   (do_pop),
        .rd_addr ({req_wid, top_ptr}),
        .rd_data (rd_data)
    );

endmodule

// File: doc/vx_ipdom_stack_mw.md
VX_IPDOM_STACK_MW -- requirements
Module: VX_ipdom_stack_mw

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each branch-target field (q0/q1/rsp_data).
REQ-002 SHALL have parameter DEPTH, default 8: entries per warp stack.
REQ-003 SHALL have parameter NUM_WARPS, default 4: number of independent stacks.
REQ-004 SHALL derive localparams ADDRW = `LOG2UP(DEPTH) and WIDW = `LOG2UP(NUM_WARPS).
REQ-005 SHALL have port clk, input, 1: the block's single clock; all state on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: request accepted when valid&&ready.
REQ-009 SHALL have port req_wid, input, WIDW: target warp.
REQ-010 SHALL have port req_push, input, 1: 1=push, 0=pop.
REQ-011 SHALL have port req_q0, input, WIDTH: reconvergence value.
REQ-012 SHALL have port req_q1, input, WIDTH: else-path value.
REQ-013 SHALL have port flush_valid, input, 1: clear one warp's stack.
REQ-014 SHALL have port flush_wid, input, WIDW: warp to flush.
REQ-015 SHALL have port rsp_valid, output, 1: pop result, no backpressure.
REQ-016 SHALL have port rsp_wid, output, WIDW: warp of the pop result.
REQ-017 SHALL have port rsp_data, output, WIDTH: popped value.
REQ-018 SHALL have port rsp_set, output, 1: 1 = first pop of an entry (else path).
REQ-019 SHALL have port empty, output, NUM_WARPS: per-warp empty.
REQ-020 SHALL have port full, output, NUM_WARPS: per-warp full.
REQ-021 SHALL have port err, output, NUM_WARPS: sticky per-warp error.

Function
REQ-022 SHALL keep per warp: wr_ptr (ADDRW+1 bits, entry count) and top_set flag; storage holds {set, q1, q0} per entry.
REQ-023 Accepted push SHALL write {0,q1,q0} at wr_ptr, increment wr_ptr, clear top_set; full asserts when count reaches DEPTH.
REQ-024 Accepted pop with top_set=0 SHALL return q1 with rsp_set=1, set the stored set bit and top_set, leave count unchanged.
REQ-025 Accepted pop with top_set=1 SHALL return q0 with rsp_set=0, decrement count, and load top_set from the new top's set bit; empty asserts at count 0.
REQ-026 rsp_valid/rsp_wid/rsp_data/rsp_set SHALL appear exactly 1 cycle after pop acceptance; pushes produce no response.
REQ-027 Back-to-back operations on the same warp SHALL be supported at full rate, with no stall and correct data.
REQ-028 Pointer decisions SHALL use registered top_set, never the RAM read data.
REQ-029 req_ready SHALL be 0 only when flush_valid && flush_wid==req_wid; otherwise 1.
REQ-030 Flush SHALL zero that warp's count, clear top_set and err, and take effect the next cycle; other warps are unaffected.
REQ-031 Flush of a warp whose pop response is in flight SHALL still deliver that response.

Reset
REQ-032 On reset_n=0, all counts and top_set SHALL clear asynchronously: empty=all 1s, full=0, err=0, rsp_valid=0.
REQ-033 rsp_data/rsp_set SHALL be don't-care during reset; storage contents are not reset.
REQ-034 An in-flight response SHALL be dropped by reset.

Configuration
REQ-035 Macro IPDOM_STACK_ERR_EN defined: a push to a full warp or pop from an empty warp is accepted but ignored (no state change, no response) and sets err[wid] until flush or reset.
REQ-036 Macro IPDOM_STACK_ERR_EN undefined: err SHALL be tied 0 and illegal operations are guarded only by simulation `ASSERT; behaviour is undefined.

Structure
REQ-037 The shared package (VX_gpu_pkg) SHALL hold the entry typedef {set, q1, q0} and the op encoding constants.
REQ-038 Storage SHALL be one sub-module, VX_ipdom_store: dual-port RAM with NUM_WARPS*DEPTH entries, address {wid, ptr}, 1-cycle registered read.

Verification (WIDTH=32, DEPTH=4, NUM_WARPS=4)
REQ-039 After reset, empty=4'hF and full=0; push w1 (q0=0x100, q1=0x200) -> empty=4'hD.
REQ-040 Pop w1 twice back-to-back -> rsp 0x200/set=1, then 0x100/set=0; empty[1]=1.
REQ-041 Push w2 four times -> full[2]=1; with ERR_EN, a fifth push -> err[2]=1, count unchanged.
REQ-042 Interleave push w0 and pop w3 each cycle -> each warp's data is correct and isolated.
REQ-043 Flush w2 while req_wid=2 -> req_ready=0; the next cycle empty[2]=1 and err[2]=0.
REQ-044 Nested: push A, push B, then pop x4 -> B.q1, B.q0, A.q1, A.q0.
